// File: rtl/rom_access_pkg.sv
// Shared types and helpers for the multi-region ROM/flash access controller.
package rom_access_pkg;

    localparam int CNT_W_DEF   = 4;
    localparam int MAX_REGIONS = 16;
    localparam int REG_IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    // True only when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [MAX_REGIONS-1:0] v);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < MAX_REGIONS; i++) begin
            if (v[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        return seen && !multi;
    endfunction

    function automatic logic [REG_IDX_W-1:0] onehot_to_idx(input logic [MAX_REGIONS-1:0] v);
        logic [REG_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REGIONS; i++) begin
            if (v[i]) idx = REG_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rom_wait_counter.sv
// Loadable down-counter shared by the wait-state and recovery phases.
module rom_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rom_access_multi.sv
// Multi-region ROM/flash access controller: CE/OE/WE strobes, wait states,
// DTACK, CE recovery and abort on FCS_n release or shutup.
module rom_access_multi
    import rom_access_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int RD_WAIT     = 2,
    parameter int WR_WAIT     = 3,
    parameter int RECOVERY    = 1,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    input  logic [NUM_REGIONS-1:0] region_sel,
    input  logic                   READ,
    input  logic                   FCS_n,
    input  logic                   shutup,
    input  logic                   wp_n,
    output logic                   rom_dtack,
    output logic [NUM_REGIONS-1:0] ROM_CE_n,
    output logic                   ROM_OE_n,
    output logic                   ROM_WE_n,
    output logic                   busy,
    output logic                   wr_blocked
);

    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] REC_LOAD = (RECOVERY > 0) ? CNT_W'(RECOVERY - 1) : '0;
    localparam logic             HAS_REC  = (RECOVERY != 0);

    function automatic logic [NUM_REGIONS-1:0] ce_decode_n(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGIONS-1:0] d;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            d[i] = (idx != REG_IDX_W'(i));
        end
        return d;
    endfunction

    state_e                 state;
    logic [MAX_REGIONS-1:0] sel_ext;
    logic [REG_IDX_W-1:0]   sel_idx;
    logic [REG_IDX_W-1:0]   idx_q;
    logic                   rd_q;
    logic                   accept;
    logic                   cyc_end;
    logic                   wr_drive;
    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_val;
    logic                   cnt_dec;
    logic                   cnt_zero;

    assign sel_ext  = MAX_REGIONS'(region_sel);
    assign sel_idx  = onehot_to_idx(sel_ext);
    assign accept   = (state == ST_IDLE) && !FCS_n && !shutup && is_one_hot(sel_ext);
    // Releasing FCS_n and asserting shutup end a cycle the same way in WAIT and ACK.
    assign cyc_end  = FCS_n || shutup;
    assign wr_drive = !READ && wp_n;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    cnt_val  = READ ? RD_LOAD : WR_LOAD;
                end
            end
            ST_WAIT: begin
                if (cyc_end) begin
                    cnt_load = 1'b1;
                    cnt_val  = REC_LOAD;
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end
            end
            ST_ACK: begin
                if (cyc_end) begin
                    cnt_load = 1'b1;
                    cnt_val  = REC_LOAD;
                end
            end
            ST_RECOVER: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    rom_wait_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Region and direction are frozen at acceptance for the whole cycle.
    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_q <= sel_idx;
            rd_q  <= READ;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= ST_IDLE;
            rom_dtack  <= 1'b0;
            ROM_CE_n   <= '1;
            ROM_OE_n   <= 1'b1;
            ROM_WE_n   <= 1'b1;
            busy       <= 1'b0;
            wr_blocked <= 1'b0;
        end else begin
            wr_blocked <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_WAIT;
                        busy       <= 1'b1;
                        ROM_CE_n   <= ce_decode_n(sel_idx);
                        ROM_OE_n   <= !READ;
                        ROM_WE_n   <= !wr_drive;
                        wr_blocked <= !READ && !wp_n;
                    end
                end
                ST_WAIT: begin
                    if (cyc_end) begin
                        if (HAS_REC) state <= ST_RECOVER;
                        else         state <= ST_IDLE;
                        busy     <= HAS_REC;
                        ROM_CE_n <= '1;
                        ROM_OE_n <= 1'b1;
                        ROM_WE_n <= 1'b1;
                    end else if (cnt_zero) begin
                        state     <= ST_ACK;
                        rom_dtack <= 1'b1;
                        ROM_WE_n  <= 1'b1;
                    end else begin
                        ROM_CE_n <= ce_decode_n(idx_q);
                        ROM_OE_n <= !rd_q;
                    end
                end
                ST_ACK: begin
                    if (cyc_end) begin
                        if (HAS_REC) state <= ST_RECOVER;
                        else         state <= ST_IDLE;
                        busy      <= HAS_REC;
                        rom_dtack <= 1'b0;
                        ROM_CE_n  <= '1;
                        ROM_OE_n  <= 1'b1;
                        ROM_WE_n  <= 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (cnt_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rom_access_multi.md
Name: rom_access_multi

Overview:
- Parametrised successor to the single-region ROM access controller on the A4092 Zorro III card.
- Serves up to NUM_REGIONS one-hot ROM/flash chip selects and generates CE/OE/WE strobes and the access-complete DTACK.
- Read and write wait states are set independently; the write pulse is gated by a flash write-protect input.
- Adds CE recovery time, cycle abort on FCS_n release, and shutup abort.

Parameters:
- NUM_REGIONS, 2: number of chip-select regions; one ROM_CE_n bit per region.
- RD_WAIT, 2: wait cycles for a read, counted after the cycle is accepted and before DTACK.
- WR_WAIT, 3: wait cycles for a write, counted after the cycle is accepted and before DTACK.
- RECOVERY, 1: cycles all strobes stay deasserted after a cycle ends; legal range 0..15.
- CNT_W, 4: counter width; must hold max(RD_WAIT, WR_WAIT, RECOVERY).

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  asynchronous, active-low reset
- region_sel  in  NUM_REGIONS  one-hot decoded address region (synchronous to CLK, synchronised upstream)
- READ  in  1  1 = read, 0 = write
- FCS_n  in  1  Zorro III full cycle strobe, active-low
- shutup  in  1  card unconfigured/shut up; blocks and aborts all accesses
- wp_n  in  1  0 = flash write-protected; writes are acknowledged but not driven to the device
- rom_dtack  out  1  access complete, active-high
- ROM_CE_n  out  NUM_REGIONS  per-region chip enable, active-low
- ROM_OE_n  out  1  output enable, active-low
- ROM_WE_n  out  1  write enable, active-low
- busy  out  1  FSM not in IDLE
- wr_blocked  out  1  one-cycle pulse when a write is suppressed by wp_n

Behaviour:
- All outputs are registered.
- Reset values: rom_dtack=0, ROM_CE_n all 1, ROM_OE_n=1, ROM_WE_n=1, busy=0, wr_blocked=0, state=IDLE, counter=0.
- States: IDLE, WAIT, ACK, RECOVER.
- IDLE: accept a cycle at edge E0 only when all hold: FCS_n=0, region_sel is exactly one-hot, shutup=0.
  - Latch region index and READ.
  - Load counter with RD_WAIT or WR_WAIT; go to WAIT.
  - At E0: ROM_CE_n[idx]=0; ROM_OE_n=0 if read.
  - At E0: ROM_WE_n=0 if write and wp_n=1; if write and wp_n=0, pulse wr_blocked instead and hold WE high.
  - Zero-hot or multi-hot region_sel: no cycle; stay in IDLE.
- WAIT: at each edge, if counter==0 go to ACK with rom_dtack<=1 and ROM_WE_n<=1; otherwise decrement the counter.
  - Resulting DTACK latency: rom_dtack rises at E0+WAIT+1, where WAIT is RD_WAIT or WR_WAIT.
  - CE and OE stay asserted through ACK.
  - WE is low for exactly WR_WAIT+1 cycles.
- ACK: hold rom_dtack=1 while FCS_n=0. When FCS_n=1 is sampled, clear DTACK, CE, and OE.
  - Then go to RECOVER with counter=RECOVERY-1, or to IDLE if RECOVERY=0.
- RECOVER: all strobes deasserted; ignore FCS_n. Count down; at 0 go to IDLE.
  - A new cycle is accepted no earlier than RECOVERY cycles after DTACK falls.
- Abort: FCS_n=1 or shutup=1 sampled in WAIT means the next edge deasserts all strobes and goes to RECOVER. rom_dtack never asserts for that cycle.
- shutup=1 in ACK: drop the strobes and DTACK immediately and go to RECOVER.
- Latched region and READ are frozen for the whole cycle; changes to region_sel or READ mid-cycle are ignored.
- Asynchronous reset mid-cycle: all outputs return to reset values immediately; no glitch low on any *_n output.
- busy = (state != IDLE).

Decomposition:
- Shared package rom_access_pkg holds:
  - the state enum (IDLE/WAIT/ACK/RECOVER);
  - the one-hot check function;
  - the one-hot-to-index function;
  - the CNT_W default constant.
- One sub-module is natural: rom_wait_counter, a loadable down-counter with load value, load strobe, and zero flag. It is shared by WAIT and RECOVER.

Test Plan:
- Read, defaults, region_sel=2'b01, FCS_n low at E0 -> CE_n=2'b10 and OE_n=0 from E0; dtack=1 at E3; FCS_n high -> dtack=0 next edge; CE high 1 cycle; busy falls after RECOVER.
- Write, wp_n=1, region_sel=2'b10 -> CE_n=2'b01; WE_n low E0..E3; dtack=1 at E4 with WE_n rising the same edge; OE_n stays 1 throughout.
- Write, wp_n=0 -> wr_blocked pulses 1 cycle at E0; WE_n stays 1; dtack still at E4; cycle completes normally.
- FCS_n released at E1 of a read -> strobes high at E2; rom_dtack stays 0; next FCS_n held low during RECOVER is not accepted until IDLE.
- region_sel=2'b11 or 2'b00, and separately shutup=1, with FCS_n low for 10 cycles -> no strobes, dtack=0, busy=0 throughout.
- RESET_n asserted mid-WAIT -> all outputs return to reset values asynchronously; after release, a fresh read completes with dtack at E3.
